// File: rtl/pr_datapath.sv
// pr_datapath: A/B/c/CNT register-transfer unit driven by the Pr_Verilog control strobes.
// Optional feature macro: PR_DP_OVF_EN adds a sticky carry-out flag on output ovf.
`default_nettype none

module pr_datapath #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         res,
  input  logic [W-1:0] din,
  input  logic         t1,
  input  logic         t2,
  input  logic         t4,
  input  logic         t5,
  input  logic         t6,
  input  logic         t7,
  input  logic         t8,
  input  logic         t9,
  output logic         x,
  output logic         y,
  output logic [W-1:0] dout,
  output logic         done
`ifdef PR_DP_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]  a_q, b_q;
  logic          c_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  a_d, b_d;
  logic          c_d;
  logic [CW-1:0] cnt_d;

  logic [W:0] sum;
  logic [W:0] ca_cat;
  logic [W:0] ab_cat;

  // Full W+1-bit sum so the carry-out is never lost.
  assign sum    = {1'b0, a_q} + {1'b0, b_q};
  assign ca_cat = {c_q, a_q};
  assign ab_cat = {a_q[0], b_q};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    cnt_d = cnt_q;

    if (t6)      a_d = '0;
    else if (t1) a_d = sum[W-1:0];
    else if (t9) a_d = ca_cat[W:1];

    if (t5)      b_d = din;
    else if (t9) b_d = ab_cat[W:1];

    if (t8)      c_d = 1'b0;
    else if (t1) c_d = sum[W];
    else if (t9) c_d = 1'b0;

    // Decrement saturates at zero.
    if (t7)                       cnt_d = CNT_LOAD;
    else if (t2 && cnt_q != '0)   cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      dout  <= '0;
      done  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      if (t4) dout <= a_q;
      done  <= t4;
    end
  end

`ifdef PR_DP_OVF_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res)                ovf <= 1'b0;
    else if (t6)             ovf <= 1'b0;
    else if (t1 && sum[W])   ovf <= 1'b1;
  end
`endif

  assign x = (cnt_q != '0);
  assign y = b_q[0];

endmodule

`default_nettype wire

// File: tb/tb_pr_datapath.sv
// Randomized and directed self-checking bench for pr_datapath (W = 8) against an arithmetic reference model.
`default_nettype none

module tb_pr_datapath;

  localparam int W = 8;

  localparam int T1 = 1, T2 = 2, T4 = 4, T5 = 8, T6 = 16, T7 = 32, T8 = 64, T9 = 128;

  logic         clk;
  logic         res;
  logic [W-1:0] din;
  logic         t1, t2, t4, t5, t6, t7, t8, t9;
  logic         x, y, done;
  logic [W-1:0] dout;
`ifdef PR_DP_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference state held as plain integers.
  int ma, mb, mc, mcnt, mdout, mdone, movf;

  pr_datapath #(.W(W)) dut (
    .clk (clk),
    .res (res),
    .din (din),
    .t1  (t1),
    .t2  (t2),
    .t4  (t4),
    .t5  (t5),
    .t6  (t6),
    .t7  (t7),
    .t8  (t8),
    .t9  (t9),
    .x   (x),
    .y   (y),
    .dout(dout),
    .done(done)
`ifdef PR_DP_OVF_EN
    ,
    .ovf (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mc = 0; mcnt = 0; mdout = 0; mdone = 0; movf = 0;
  endtask

  task automatic drive(input int s, input int d);
    t1 = (s & T1) != 0; t2 = (s & T2) != 0; t4 = (s & T4) != 0; t5 = (s & T5) != 0;
    t6 = (s & T6) != 0; t7 = (s & T7) != 0; t8 = (s & T8) != 0; t9 = (s & T9) != 0;
    din = d[W-1:0];
  endtask

  // Lowest-priority effects first, higher-priority strobes overwrite them.
  task automatic model_step(input int s, input int d);
    int sum, cat, na, nb, nc, ncnt;
    sum = ma + mb;
    na = ma; nb = mb; nc = mc; ncnt = mcnt;
    if (s & T9) begin
      cat = (mc * 65536 + ma * 256 + mb) / 2;
      na = (cat / 256) % 256;
      nb = cat % 256;
      nc = 0;
    end
    if (s & T1) begin
      na = sum % 256;
      nc = sum / 256;
    end
    if (s & T6) na = 0;
    if (s & T5) nb = d % 256;
    if (s & T8) nc = 0;
    if ((s & T2) && mcnt > 0) ncnt = mcnt - 1;
    if (s & T7) ncnt = W;
    if ((s & T1) && sum > 255) movf = 1;
    if (s & T6) movf = 0;
    if (s & T4) mdout = ma;
    mdone = (s & T4) ? 1 : 0;
    ma = na; mb = nb; mc = nc; mcnt = ncnt;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".x"},    32'(x),    32'(mcnt != 0));
    check({tag, ".y"},    32'(y),    32'(mb % 2));
    check({tag, ".dout"}, 32'(dout), 32'(mdout));
    check({tag, ".done"}, 32'(done), 32'(mdone));
`ifdef PR_DP_OVF_EN
    check({tag, ".ovf"},  32'(ovf),  32'(movf));
`endif
  endtask

  // One clock: drive after the previous edge, update the model at the edge, check 1ns later.
  task automatic cyc(input string tag, input int s, input int d);
    drive(s, d);
    @(posedge clk);
    model_step(s, d);
    #1;
    check_outputs(tag);
  endtask

  // Reads A through dout without disturbing other state.
  task automatic read_a(input string tag, input int exp_a);
    cyc(tag, T4, 0);
    cyc({tag, "_d"}, 0, 0);
    check({tag, ".a"}, 32'(dout), 32'(exp_a));
  endtask

  task automatic async_reset(input string tag);
    #3;
    res = 1'b0;
    #1;
    model_reset();
    check({tag, ".x"},    32'(x),    0);
    check({tag, ".y"},    32'(y),    0);
    check({tag, ".dout"}, 32'(dout), 0);
    check({tag, ".done"}, 32'(done), 0);
  endtask

  initial begin
    int s, guard;
    res = 1'b0;
    drive(0, 0);
    model_reset();
    #12;
    check_outputs("por");
    @(negedge clk);
    res = 1'b1;

    // Load / decode and counter saturation.
    cyc("ld_b", T5, 8'h35);
    cyc("ld_cnt", T7, 0);
    check("ld.y", 32'(y), 1);
    check("ld.x", 32'(x), 1);
    for (int i = 0; i < 8; i++) cyc("dec", T2, 0);
    check("dec8.x", 32'(x), 0);
    cyc("dec9", T2, 0);
    check("sat.x", 32'(x), 0);
    cyc("sat_idle", 0, 0);
    check("sat2.x", 32'(x), 0);

    // Concurrency: A=10, B=03, then t1+t5+t6 with din=FF.
    cyc("cc0", T6 | T8, 0);
    cyc("cc1", T5, 8'h10);
    cyc("cc2", T1, 0);
    cyc("cc3", T5, 8'h03);
    cyc("cc4", T1 | T5 | T6, 8'hFF);
    check("cc.y", 32'(y), 1);
    read_a("cc.a0", 8'h00);
    cyc("cc5", T7 | T8, 0);
    check("cc.x", 32'(x), 1);
    cyc("cc6", T9, 0);
    read_a("cc.c0", 8'h00);

    // Carry: A=F0 + B=20 -> A=10, c=1; shift -> A=88.
    cyc("cy0", T6 | T8, 0);
    cyc("cy1", T5, 8'hF0);
    cyc("cy2", T1, 0);
    cyc("cy3", T5, 8'h20);
    cyc("cy4", T1, 0);
    read_a("cy.a", 8'h10);
    cyc("cy5", T9, 0);
    read_a("cy.sh", 8'h88);
`ifdef PR_DP_OVF_EN
    check("cy.ovf_sticky", 32'(ovf), 1);
    cyc("cy6", T6, 0);
    check("cy.ovf_clr", 32'(ovf), 0);
`endif

    // t4 with t1 captures pre-edge A; back-to-back t4 keeps done high.
    cyc("t41", T4 | T1, 0);
    cyc("t42", T4, 0);
    check("t4.done_hold", 32'(done), 1);

    // FSM-style shift-add sequence.
    cyc("mul0", T6 | T8 | T7 | T5, 8'd11);
    guard = 0;
    while (mcnt != 0 && guard < 20) begin
      if (mb % 2 == 1) cyc("mul_add", T1, 0);
      cyc("mul_sh", T9 | T2, 0);
      guard++;
    end
    check("mul.bound", 32'(guard < 20), 1);
    cyc("mul_out", T4, 0);
    check("mul.done", 32'(done), 1);
    cyc("mul_end", 0, 0);
    check("mul.done_pulse", 32'(done), 0);

    // Mid-operation reset after three iterations, with t4 asserted while in reset.
    cyc("mr0", T6 | T8 | T7 | T5, 8'd13);
    for (int i = 0; i < 3; i++) begin
      if (mb % 2 == 1) cyc("mr_add", T1, 0);
      cyc("mr_sh", T9 | T2, 0);
    end
    drive(T4 | T1, 0);
    async_reset("mr");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("mr.hold_dout", 32'(dout), 0);
      check("mr.hold_done", 32'(done), 0);
      check("mr.hold_x", 32'(x), 0);
    end
    res = 1'b1;
    cyc("mr_restart", T6 | T8 | T7 | T5, 8'd13);
    guard = 0;
    while (mcnt != 0 && guard < 20) begin
      if (mb % 2 == 1) cyc("mr_add2", T1, 0);
      cyc("mr_sh2", T9 | T2, 0);
      guard++;
    end
    cyc("mr_out", T4, 0);

    // Random strobe mixes against the reference model.
    for (int i = 0; i < 400; i++) begin
      s = 0;
      for (int b = 0; b < 8; b++) if ($urandom_range(3) == 0) s |= (1 << b);
      cyc("rnd", s, int'($urandom_range(255)));
    end

    // Asynchronous reset from random state, mid-clock.
    async_reset("arst");
    @(negedge clk);
    res = 1'b1;
    read_a("arst.a", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
